nanov_spi_mem: RTL and testbench

Synthesizable SPI memory responder: the device end of the single-bit SPI link that the nanoV CPU drives for instruction fetch, loads and stores. It decodes the 8-bit command, 24-bit address and data phases on the CPU's `spi_out`/`spi_select`/`spi_clk_enable` signals and returns read data on the CPU's `spi_data_in`. It runs on the CPU's own `clk`, so a CPU, this block and a small program image make a self-contained system for FPGA bring-up and simulation.

---
 rtl/nanov_spi_pkg.sv | 19 +
 rtl/nanov_spi_mem_array.sv | 29 ++
 rtl/nanov_spi_mem.sv | 169 ++++++++++++++++
 tb/tb_nanov_spi_mem.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nanov_spi_pkg.sv
// nanov_spi_pkg: shared constants and state type for the nanoV SPI memory
// responder (command opcodes, address-phase length, FSM state encoding).
package nanov_spi_pkg;

   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam logic [7:0] CMD_WRITE = 8'h02;

   localparam int ADDR_PHASE_BITS = 24;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CMD    = 3'd1,
      ST_ADDR   = 3'd2,
      ST_READ   = 3'd3,
      ST_WRITE  = 3'd4,
      ST_IGNORE = 3'd5
   } spiState_t;

endpackage

// File: rtl/nanov_spi_mem_array.sv
// nanov_spi_mem_array: 2^ADDR_BITS x 8 byte RAM with one synchronous read
// port and one write port. Write arbitration is done by the parent.
module nanov_spi_mem_array
   import nanov_spi_pkg::*;
#(
   parameter int ADDR_BITS = 10
) (
   input  logic                 clk,
   input  logic                 i_wrEn,
   input  logic [ADDR_BITS-1:0] i_wrAddr,
   input  logic [7:0]           i_wrData,
   input  logic                 i_rdEn,
   input  logic [ADDR_BITS-1:0] i_rdAddr,
   output logic [7:0]           o_rdData
);

   logic [7:0] r_mem [0:(1<<ADDR_BITS)-1];

   // Byte write and registered byte read; the read data holds until the next fetch.
   always_ff @(posedge clk) begin
      if (i_wrEn) begin
         r_mem[i_wrAddr] <= i_wrData;
      end
      if (i_rdEn) begin
         o_rdData <= r_mem[i_rdAddr];
      end
   end

endmodule

// File: rtl/nanov_spi_mem.sv
// nanov_spi_mem: device end of the nanoV single-bit SPI memory link.
// Decodes command / 24-bit address / data phases and streams read data
// back MSB first. Define NANOV_SPI_MEM_WRITE_EN to accept command 0x02
// (SPI RAM behaviour); otherwise only the backdoor load port writes memory.
module nanov_spi_mem
   import nanov_spi_pkg::*;
#(
   parameter int ADDR_BITS = 10
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 spi_select,
   input  logic                 spi_clk_enable,
   input  logic                 spi_mosi,
   output logic                 spi_miso,
   input  logic                 load_en,
   input  logic [ADDR_BITS-1:0] load_addr,
   input  logic [7:0]           load_data
);

   // Only the low bits of a shifted word are ever consumed: the command
   // needs 7 history bits, the address needs ADDR_BITS-1.
   localparam int SHIFT_BITS = (ADDR_BITS - 1 > 7) ? ADDR_BITS - 1 : 7;
   localparam logic [ADDR_BITS-1:0] ADDR_ONE = 1;
   localparam logic [4:0] ADDR_LAST = 5'(ADDR_PHASE_BITS - 1);

   spiState_t             r_state;
   logic [4:0]            r_cnt;
   logic [SHIFT_BITS-1:0] r_shift;
   logic [ADDR_BITS-1:0]  r_addr;

   logic                  w_enabled;
   logic [7:0]            w_cmdByte;
   logic [ADDR_BITS-1:0]  w_addrNew;
   logic                  w_addrDone;
   logic                  w_byteDone;
   logic                  w_fetchFirst;
   logic                  w_rdEn;
   logic [ADDR_BITS-1:0]  w_rdAddr;
   logic [7:0]            w_rdData;
   logic                  w_wrEn;
   logic [ADDR_BITS-1:0]  w_wrAddr;
   logic [7:0]            w_wrData;

   assign w_enabled  = ~spi_select & spi_clk_enable;
   assign w_cmdByte  = {r_shift[6:0], spi_mosi};
   assign w_addrNew  = {r_shift[ADDR_BITS-2:0], spi_mosi};
   assign w_addrDone = (r_state == ST_ADDR) && (r_cnt == ADDR_LAST);
   assign w_byteDone = (r_state == ST_READ) && (r_cnt == 5'd7);

`ifdef NANOV_SPI_MEM_WRITE_EN
   logic r_isWrite;
   logic w_spiWr;

   assign w_fetchFirst = w_addrDone & ~r_isWrite;
   assign w_spiWr      = w_enabled && (r_state == ST_WRITE) && (r_cnt == 5'd7);
   // SPI store takes the single write port; backdoor only gets it when idle.
   assign w_wrEn       = w_spiWr | load_en;
   assign w_wrAddr     = w_spiWr ? r_addr : load_addr;
   assign w_wrData     = w_spiWr ? w_cmdByte : load_data;
`else
   assign w_fetchFirst = w_addrDone;
   assign w_wrEn       = load_en;
   assign w_wrAddr     = load_addr;
   assign w_wrData     = load_data;
`endif

   // First fetch uses the address completing on this edge; later fetches
   // use the next sequential address so consecutive bytes have no gap.
   assign w_rdEn   = w_enabled & (w_fetchFirst | w_byteDone);
   assign w_rdAddr = (r_state == ST_ADDR) ? w_addrNew : (r_addr + ADDR_ONE);

   // Output bit is selected from the registered read byte, so it only
   // changes on enabled edges and drops to 0 whenever we leave READ.
   assign spi_miso = (r_state == ST_READ) ? w_rdData[3'd7 - r_cnt[2:0]] : 1'b0;

   nanov_spi_mem_array #(
      .ADDR_BITS (ADDR_BITS)
   ) u_array (
      .clk      (clk),
      .i_wrEn   (w_wrEn),
      .i_wrAddr (w_wrAddr),
      .i_wrData (w_wrData),
      .i_rdEn   (w_rdEn),
      .i_rdAddr (w_rdAddr),
      .o_rdData (w_rdData)
   );

   // Transaction FSM: command, address and data phases advance one bit per enabled edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ST_IDLE;
         r_cnt   <= 5'd0;
         r_shift <= '0;
         r_addr  <= '0;
`ifdef NANOV_SPI_MEM_WRITE_EN
         r_isWrite <= 1'b0;
`endif
      end else if (spi_select) begin
         r_state <= ST_IDLE;
         r_cnt   <= 5'd0;
      end else if (spi_clk_enable) begin
         r_shift <= {r_shift[SHIFT_BITS-2:0], spi_mosi};
         case (r_state)
            ST_IDLE: begin
               r_state <= ST_CMD;
               r_cnt   <= 5'd1;
            end
            ST_CMD: begin
               if (r_cnt == 5'd7) begin
                  r_cnt <= 5'd0;
                  if (w_cmdByte == CMD_READ) begin
                     r_state <= ST_ADDR;
`ifdef NANOV_SPI_MEM_WRITE_EN
                     r_isWrite <= 1'b0;
                  end else if (w_cmdByte == CMD_WRITE) begin
                     r_state   <= ST_ADDR;
                     r_isWrite <= 1'b1;
`endif
                  end else begin
                     r_state <= ST_IGNORE;
                  end
               end else begin
                  r_cnt <= r_cnt + 5'd1;
               end
            end
            ST_ADDR: begin
               if (r_cnt == ADDR_LAST) begin
                  r_cnt  <= 5'd0;
                  r_addr <= w_addrNew;
`ifdef NANOV_SPI_MEM_WRITE_EN
                  r_state <= r_isWrite ? ST_WRITE : ST_READ;
`else
                  r_state <= ST_READ;
`endif
               end else begin
                  r_cnt <= r_cnt + 5'd1;
               end
            end
            ST_READ: begin
               if (r_cnt == 5'd7) begin
                  r_cnt  <= 5'd0;
                  r_addr <= r_addr + ADDR_ONE;
               end else begin
                  r_cnt <= r_cnt + 5'd1;
               end
            end
`ifdef NANOV_SPI_MEM_WRITE_EN
            ST_WRITE: begin
               if (r_cnt == 5'd7) begin
                  r_cnt  <= 5'd0;
                  r_addr <= r_addr + ADDR_ONE;
               end else begin
                  r_cnt <= r_cnt + 5'd1;
               end
            end
`endif
            ST_IGNORE: begin
               r_state <= ST_IGNORE;
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= 5'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nanov_spi_mem.sv
// tb_nanov_spi_mem: directed plus randomized bench for nanov_spi_mem.
// Keeps a byte-array image of the memory and predicts every spi_miso bit
// from it. Write tests are built only when NANOV_SPI_MEM_WRITE_EN is defined.
module tb_nanov_spi_mem;

   localparam int AB    = 10;
   localparam int DEPTH = 1 << AB;

   logic          clk = 1'b0;
   logic          rstn;
   logic          spi_select;
   logic          spi_clk_enable;
   logic          spi_mosi;
   logic          spi_miso;
   logic          load_en;
   logic [AB-1:0] load_addr;
   logic [7:0]    load_data;

   logic [7:0] model [DEPTH];
   int nVec  = 0;
   int nFail = 0;

   always #5 clk = ~clk;

   nanov_spi_mem #(
      .ADDR_BITS (AB)
   ) dut (
      .clk            (clk),
      .rstn           (rstn),
      .spi_select     (spi_select),
      .spi_clk_enable (spi_clk_enable),
      .spi_mosi       (spi_mosi),
      .spi_miso       (spi_miso),
      .load_en        (load_en),
      .load_addr      (load_addr),
      .load_data      (load_data)
   );

   // Address of byte 'off' of a burst starting at 24-bit address a, after aliasing and wrap.
   function automatic logic [AB-1:0] wrapAddr(input logic [23:0] a, input int off);
      return AB'((int'(a) + off) % DEPTH);
   endfunction

   task automatic checkOutput(input string tag, input logic expBit);
      nVec++;
      assert (spi_miso === expBit) else begin
         nFail++;
         $error("[TB] FAIL %s: spi_miso=%b required=%b", tag, spi_miso, expBit);
      end
   endtask

   // One clock: drive on the falling edge, return just after the rising edge.
   task automatic applyStimulus(input logic sel, input logic en, input logic mosi);
      @(negedge clk);
      spi_select     = sel;
      spi_clk_enable = en;
      spi_mosi       = mosi;
      @(posedge clk);
      #1;
   endtask

   task automatic sendByte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) applyStimulus(1'b0, 1'b1, b[i]);
   endtask

   task automatic sendAddr(input logic [23:0] a);
      for (int i = 23; i >= 0; i--) applyStimulus(1'b0, 1'b1, a[i]);
   endtask

   task automatic deselect(input string tag);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput(tag, 1'b0);
   endtask

   task automatic preload(input logic [AB-1:0] a, input logic [7:0] d);
      @(negedge clk);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      @(posedge clk);
      #1;
      load_en = 1'b0;
      model[a] = d;
   endtask

   // Read burst; optionally stall the bit strobe for 5 cycles after gapAfter data bits.
   task automatic readCheck(input string tag, input logic [23:0] a, input int nBytes, input int gapAfter);
      logic [7:0] expByte;
      int bitsDone;
      bitsDone = 0;
      sendByte(8'h03);
      sendAddr(a);
      for (int b = 0; b < nBytes; b++) begin
         expByte = model[wrapAddr(a, b)];
         for (int k = 7; k >= 0; k--) begin
            if (bitsDone == gapAfter) begin
               for (int g = 0; g < 5; g++) begin
                  applyStimulus(1'b0, 1'b0, 1'($urandom));
                  checkOutput({tag, " gap hold"}, expByte[k]);
               end
            end
            checkOutput(tag, expByte[k]);
            applyStimulus(1'b0, 1'b1, 1'($urandom));
            bitsDone++;
         end
      end
      deselect({tag, " deselect"});
   endtask

   // Unsupported command followed by 32 bits: output must stay low throughout.
   task automatic ignoreCheck(input string tag, input logic [7:0] cmd);
      sendByte(cmd);
      for (int i = 0; i < 32; i++) begin
         applyStimulus(1'b0, 1'b1, 1'($urandom));
         checkOutput(tag, 1'b0);
      end
      deselect({tag, " deselect"});
   endtask

`ifdef NANOV_SPI_MEM_WRITE_EN
   task automatic writeBytes(input logic [23:0] a, input logic [7:0] d0, input logic [7:0] d1, input int n);
      sendByte(8'h02);
      sendAddr(a);
      sendByte(d0);
      model[wrapAddr(a, 0)] = d0;
      if (n > 1) begin
         sendByte(d1);
         model[wrapAddr(a, 1)] = d1;
      end
      deselect("write deselect");
   endtask
`endif

   // Write command cut off after 4 data bits; target byte must survive.
   task automatic partialWrite(input logic [23:0] a);
      sendByte(8'h02);
      sendAddr(a);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'($urandom));
      deselect("partial write deselect");
   endtask

   initial begin
      logic [23:0] rAddr;
      int          rLen;
      rstn           = 1'b0;
      spi_select     = 1'b1;
      spi_clk_enable = 1'b0;
      spi_mosi       = 1'b0;
      load_en        = 1'b0;
      load_addr      = '0;
      load_data      = '0;
      $display("[TB] start");

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset miso", 1'b0);
      @(negedge clk);
      rstn = 1'b1;

      // Fill the whole array so every read has a defined expectation.
      for (int i = 0; i < DEPTH; i++) preload(AB'(i), 8'($urandom));

      // Basic two-byte read, first bit one cycle after address bit 0.
      preload(10'h010, 8'hA5);
      preload(10'h011, 8'h3C);
      readCheck("read 0x10", 24'h000010, 2, -1);

      // Wrap at the top of memory, then the aliased address.
      preload(10'h3FF, 8'h11);
      preload(10'h000, 8'h22);
      readCheck("read wrap", 24'h0003FF, 2, -1);
      readCheck("read alias", 24'h0403FF, 2, -1);

      // Strobe stalls mid-byte.
      readCheck("read gap", 24'h000010, 2, 3);

`ifdef NANOV_SPI_MEM_WRITE_EN
      writeBytes(24'h000200, 8'hDE, 8'hAD, 2);
      readCheck("read after write", 24'h000200, 2, -1);
`endif

      preload(10'h300, 8'h5A);
      partialWrite(24'h000300);
      readCheck("read after partial write", 24'h000300, 1, -1);

      // Reset in the middle of the address phase, then a fresh read.
      sendByte(8'h03);
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'($urandom));
      @(negedge clk);
      spi_clk_enable = 1'b0;
      rstn = 1'b0;
      #1;
      checkOutput("reset mid-address", 1'b0);
      @(negedge clk);
      rstn = 1'b1;
      readCheck("read after reset", 24'h000011, 1, -1);

      // Asynchronous reset while a 1 is being driven.
      sendByte(8'h03);
      sendAddr(24'h000010);
      checkOutput("pre-reset bit7", model[10'h010][7]);
      #2;
      rstn = 1'b0;
      #1;
      checkOutput("async reset miso", 1'b0);
      spi_clk_enable = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      deselect("post-reset deselect");

      // Unsupported commands leave memory and output untouched.
      ignoreCheck("ignore 0x9F", 8'h9F);
      readCheck("read after 0x9F", 24'h000010, 2, -1);
`ifndef NANOV_SPI_MEM_WRITE_EN
      preload(10'h200, 8'hC3);
      sendByte(8'h02);
      sendAddr(24'h000200);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 1'b1, 1'($urandom));
         checkOutput("ignore 0x02", 1'b0);
      end
      deselect("ignore 0x02 deselect");
      readCheck("read after ignored write", 24'h000200, 1, -1);
`endif

      // Randomized traffic against the memory image.
      for (int t = 0; t < 20; t++) begin
         preload(AB'($urandom), 8'($urandom));
         rAddr = 24'($urandom);
         rLen  = int'($urandom_range(1, 3));
`ifdef NANOV_SPI_MEM_WRITE_EN
         if ($urandom_range(0, 1) == 1) begin
            writeBytes(rAddr, 8'($urandom), 8'($urandom), int'($urandom_range(1, 2)));
         end
`endif
         readCheck("random read", rAddr, rLen, int'($urandom_range(0, 12)) - 2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
      $finish;
   end

endmodule
